hps_key_in: RTL and testbench

//  Avalon-MM slave input port for the HPS: samples WIDTH external inputs (push keys),

---
 rtl/hps_key_in_if.sv | 20 ++
 rtl/hps_key_in.sv | 143 ++++++++++++++
 tb/tb_hps_key_in.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hps_key_in_if.sv
// Avalon-MM slave bus bundle for the HPS key input port.
// The master drives the request; the slave returns registered read data and the level IRQ.
interface hps_key_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/hps_key_in.sv
// HPS push-key input port: synchronizes external inputs, latches edges into a sticky
// W1C capture register and raises a masked level interrupt over an Avalon-MM slave.
module hps_key_in #(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    hps_key_in_if.slave      bus
);

    localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [2:0]       r_prime_cnt;
    logic             r_primed;
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_raw_edge;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    assign w_data   = r_sync[SYNC_STAGES-1];
    assign w_wdata  = bus.writedata[WIDTH-1:0];
    assign w_unused = &{1'b0, bus.writedata};

    assign bus.readdata = r_readdata;
    assign bus.irq      = r_irq;

    // Synchronizer chain plus the one-cycle-old sample used for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= {WIDTH{1'b0}};
            end
            r_prev <= {WIDTH{1'b0}};
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_data;
        end
    end

    // Priming: the chain fills with zeros at reset, so ignore edges until it holds real samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prime_cnt <= 3'd0;
            r_primed    <= 1'b0;
        end else if (!r_primed) begin
            if (r_prime_cnt == PRIME_LAST) begin
                r_primed <= 1'b1;
            end else begin
                r_prime_cnt <= r_prime_cnt + 3'd1;
            end
        end else begin
            r_primed <= 1'b1;
        end
    end

    // Bus decode, edge selection and W1C clear vector
    always_comb begin
        w_wr       = bus.chipselect & ~bus.write_n;
        w_rd       = bus.chipselect & bus.write_n;
        w_raw_edge = {WIDTH{1'b0}};
        w_clr      = {WIDTH{1'b0}};
        case (EDGE_TYPE)
            32'sd0:  w_raw_edge = w_data & ~r_prev;
            32'sd1:  w_raw_edge = ~w_data & r_prev;
            default: w_raw_edge = w_data ^ r_prev;
        endcase
        if (r_primed) begin
            w_edge = w_raw_edge;
        end else begin
            w_edge = {WIDTH{1'b0}};
        end
        if (w_wr && (bus.address == 2'd3)) begin
            w_clr = w_wdata;
        end else begin
            w_clr = {WIDTH{1'b0}};
        end
    end

    // Read multiplexer; unused upper bits stay zero
    always_comb begin
        w_rd_mux = 32'd0;
        case (bus.address)
            2'd0:    w_rd_mux[WIDTH-1:0] = w_data;
            2'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
            2'd3:    w_rd_mux[WIDTH-1:0] = r_cap;
            default: w_rd_mux = 32'd0;
        endcase
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= {WIDTH{1'b0}};
        end else if (w_wr && (bus.address == 2'd2)) begin
            r_mask <= w_wdata;
        end else begin
            r_mask <= r_mask;
        end
    end

    // Sticky edge capture; a new edge overrides a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap <= {WIDTH{1'b0}};
        end else begin
            r_cap <= w_edge | (r_cap & ~w_clr);
        end
    end

    // Registered level interrupt and read data (read data holds when idle)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq      <= 1'b0;
            r_readdata <= 32'd0;
        end else begin
            r_irq <= |(r_cap & r_mask);
            if (w_rd) begin
                r_readdata <= w_rd_mux;
            end else begin
                r_readdata <= r_readdata;
            end
        end
    end

endmodule

// File: tb/tb_hps_key_in.sv
// Self-checking bench for hps_key_in: directed scenarios plus randomized traffic
// compared against a cycle-level reference model built from input history.
module tb_hps_key_in;

    localparam int WIDTH     = 4;
    localparam int EDGE_TYPE = 1;
    localparam int SYNC      = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_port = 4'hF;

    hps_key_in_if bus ();

    hps_key_in #(
        .WIDTH       (WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: in_port value seen at each clock edge since reset
    logic [3:0]  hist [$];
    logic [3:0]  m_cap;
    logic [3:0]  m_mask;
    logic        m_irq;
    logic [31:0] m_rdata;

    function automatic logic [3:0] hist_at(int j);
        if (j < 1 || j > hist.size()) return 4'h0;
        return hist[j-1];
    endfunction

    task automatic model_clear();
        hist.delete();
        m_cap   = 4'h0;
        m_mask  = 4'h0;
        m_irq   = 1'b0;
        m_rdata = 32'd0;
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then settle
    task automatic tick();
        logic [3:0]  cur;
        logic [3:0]  old;
        logic [3:0]  edges;
        logic [3:0]  clr;
        logic [31:0] rd;
        int k;
        @(posedge clk);
        if (!reset_n) begin
            model_clear();
        end else begin
            hist.push_back(in_port);
            k     = hist.size();
            cur   = hist_at(k - SYNC);
            old   = hist_at(k - SYNC - 1);
            edges = 4'h0;
            if (k >= SYNC + 2) begin
                if (EDGE_TYPE == 0)      edges = cur & ~old;
                else if (EDGE_TYPE == 1) edges = ~cur & old;
                else                     edges = cur ^ old;
            end
            rd = 32'd0;
            if (bus.address == 2'd0) rd = {28'd0, cur};
            if (bus.address == 2'd2) rd = {28'd0, m_mask};
            if (bus.address == 2'd3) rd = {28'd0, m_cap};
            clr = (bus.chipselect && !bus.write_n && bus.address == 2'd3) ? bus.writedata[3:0] : 4'h0;
            m_irq = |(m_cap & m_mask);
            if (bus.chipselect && bus.write_n) m_rdata = rd;
            if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask = bus.writedata[3:0];
            m_cap = edges | (m_cap & ~clr);
        end
        #1;
    endtask

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = 32'd0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        tick();
        bus_idle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_clear();
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        in_port = 4'hF;
        do_reset();
        repeat (10) tick();
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq got %0b want 0", bus.irq);
        end
        bus_read(2'd3);
        checks++;
        if (bus.readdata !== 32'd0) begin
            errors++; $display("FAIL reset_edgecap got %h want 0", bus.readdata);
        end
        bus_read(2'd0);
        checks++;
        if (bus.readdata !== 32'h0000000F) begin
            errors++; $display("FAIL reset_data got %h want 0000000f", bus.readdata);
        end
        bus_read(2'd2);
        checks++;
        if (bus.readdata !== 32'd0) begin
            errors++; $display("FAIL reset_mask got %h want 0", bus.readdata);
        end
    endtask

    task automatic test_edge_capture();
        in_port = 4'hE;
        repeat (SYNC + 1) tick();
        bus_read(2'd3);
        checks++;
        if (bus.readdata !== 32'h1) begin
            errors++; $display("FAIL edge_cap got %h want 1", bus.readdata);
        end
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++; $display("FAIL edge_irq_masked got %0b want 0", bus.irq);
        end
        bus_write(2'd2, 32'h1);
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++; $display("FAIL mask_irq_early got %0b want 0", bus.irq);
        end
        tick();
        checks++;
        if (bus.irq !== 1'b1) begin
            errors++; $display("FAIL mask_irq got %0b want 1", bus.irq);
        end
    endtask

    task automatic test_w1c();
        bus_read(2'd3);
        bus_read(2'd3);
        checks++;
        if (bus.readdata !== 32'h1 || bus.irq !== 1'b1) begin
            errors++; $display("FAIL read_no_clear got %h/%0b want 1/1", bus.readdata, bus.irq);
        end
        bus_write(2'd3, 32'h1);
        tick();
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++; $display("FAIL w1c_irq got %0b want 0", bus.irq);
        end
        bus_read(2'd3);
        checks++;
        if (bus.readdata !== 32'd0) begin
            errors++; $display("FAIL w1c_cap got %h want 0", bus.readdata);
        end
    endtask

    task automatic test_edge_wins();
        bus_write(2'd2, 32'h4);
        in_port = 4'hA;
        repeat (SYNC + 1) tick();
        in_port = 4'hE;
        repeat (4) tick();
        in_port = 4'hA;
        repeat (SYNC) tick();
        bus_write(2'd3, 32'h4);
        checks++;
        if (bus.irq !== 1'b1) begin
            errors++; $display("FAIL edge_wins_irq0 got %0b want 1", bus.irq);
        end
        tick();
        checks++;
        if (bus.irq !== 1'b1) begin
            errors++; $display("FAIL edge_wins_irq1 got %0b want 1", bus.irq);
        end
        bus_read(2'd3);
        checks++;
        if (bus.readdata !== 32'h4) begin
            errors++; $display("FAIL edge_wins_cap got %h want 4", bus.readdata);
        end
    endtask

    task automatic test_read_data();
        in_port = 4'hA;
        repeat (SYNC + 1) tick();
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        checks++;
        if (bus.readdata !== 32'h4) begin
            errors++; $display("FAIL read_hold_pre got %h want 4", bus.readdata);
        end
        tick();
        bus_idle();
        checks++;
        if (bus.readdata !== 32'h0000000A) begin
            errors++; $display("FAIL read_data got %h want 0000000a", bus.readdata);
        end
        bus_read(2'd1);
        checks++;
        if (bus.readdata !== 32'd0) begin
            errors++; $display("FAIL read_addr1 got %h want 0", bus.readdata);
        end
        bus_read(2'd2);
        checks++;
        if (bus.readdata !== 32'h4) begin
            errors++; $display("FAIL read_mask got %h want 4", bus.readdata);
        end
        tick();
        checks++;
        if (bus.readdata !== 32'h4) begin
            errors++; $display("FAIL read_hold got %h want 4", bus.readdata);
        end
    endtask

    task automatic test_reset_mid();
        checks++;
        if (bus.irq !== 1'b1) begin
            errors++; $display("FAIL mid_pre_irq got %0b want 1", bus.irq);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.irq !== 1'b0 || bus.readdata !== 32'd0) begin
            errors++; $display("FAIL mid_async got %0b/%h want 0/0", bus.irq, bus.readdata);
        end
        model_clear();
        repeat (2) tick();
        in_port = 4'hF;
        reset_n = 1'b1;
        repeat (6) tick();
        bus_read(2'd3);
        checks++;
        if (bus.readdata !== 32'd0) begin
            errors++; $display("FAIL mid_cap got %h want 0", bus.readdata);
        end
        bus_read(2'd2);
        checks++;
        if (bus.readdata !== 32'd0) begin
            errors++; $display("FAIL mid_mask got %h want 0", bus.readdata);
        end
    endtask

    task automatic test_random();
        int op;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 4) == 0) in_port = 4'($urandom);
            op = $urandom_range(0, 9);
            bus_idle();
            if (op < 4) begin
                bus.chipselect = 1'b1;
                bus.write_n    = 1'b1;
                bus.address    = 2'($urandom);
            end else if (op < 6) begin
                bus.chipselect = 1'b1;
                bus.write_n    = 1'b0;
                bus.address    = 2'($urandom);
                bus.writedata  = $urandom;
            end
            tick();
            checks++;
            if (bus.irq !== m_irq) begin
                errors++; $display("FAIL rand_irq n=%0d got %0b want %0b", n, bus.irq, m_irq);
            end
            checks++;
            if (bus.readdata !== m_rdata) begin
                errors++; $display("FAIL rand_rdata n=%0d got %h want %h", n, bus.readdata, m_rdata);
            end
        end
        bus_idle();
    endtask

    initial begin
        bus_idle();
        model_clear();
        test_reset();
        test_edge_capture();
        test_w1c();
        test_edge_wins();
        test_read_data();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
